// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences fetch/decode/execute/memory/writeback with a memory-stall watchdog.
module multicycle_ctrl #(
   parameter int DATAWIDTH  = 32,
   parameter int WAIT_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATAWIDTH-1:0] Instr_i,
   input  logic                 MemReady_i,
   input  logic                 BranchCond_i,
   output logic [2:0]           ImmSrc_o,
   output logic                 PCWrite_o,
   output logic                 IRWrite_o,
   output logic                 AdrSrc_o,
   output logic                 MemRead_o,
   output logic                 MemWrite_o,
   output logic                 RegWrite_o,
   output logic [1:0]           ALUSrcA_o,
   output logic [1:0]           ALUSrcB_o,
   output logic [1:0]           ALUOp_o,
   output logic [1:0]           ResultSrc_o,
   output logic                 Halted_o
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXEC_R,
      S_EXEC_I,
      S_LUI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_JALR_ADR,
      S_TRAP
   } state_t;

   localparam int CW =
      (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
   localparam logic [CW-1:0] LIM =
      CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);
   localparam bit WD_ON = (WAIT_LIMIT > 0);

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] wcnt;

   logic [6:0] opcode;
   logic       is_load;
   logic       is_store;
   logic       is_r;
   logic       is_i;
   logic       is_branch;
   logic       is_jal;
   logic       is_jalr;
   logic       is_lui;
   logic       stall;
   logic       timeout;
   logic       unused_bits;

   assign opcode    = Instr_i[6:0];
   assign is_load   = (opcode == 7'b0000011);
   assign is_store  = (opcode == 7'b0100011);
   assign is_r      = (opcode == 7'b0110011);
   assign is_i      = (opcode == 7'b0010011);
   assign is_branch = (opcode == 7'b1100011);
   assign is_jal    = (opcode == 7'b1101111);
   assign is_jalr   = (opcode == 7'b1100111);
   assign is_lui    = (opcode == 7'b0110111);

   // funct3 is evaluated by the ALU; the rest of the word never steers control
   assign unused_bits = ^Instr_i[DATAWIDTH-1:7];

   assign stall = (state == S_FETCH || state == S_MEMREAD ||
                   state == S_MEMWRITE) && !MemReady_i;
   assign timeout = WD_ON && stall && (wcnt == LIM);

   // Next-state selection; a ready memory in the limit cycle beats the watchdog
   always_comb begin
      nxt = state;
      case (state)
         S_FETCH: begin
            if (MemReady_i)   nxt = S_DECODE;
            else if (timeout) nxt = S_TRAP;
         end
         S_DECODE: begin
            unique case (1'b1)
               is_load, is_store: nxt = S_MEMADR;
               is_r:              nxt = S_EXEC_R;
               is_i:              nxt = S_EXEC_I;
               is_branch:         nxt = S_BRANCH;
               is_jal:            nxt = S_JAL;
               is_jalr:           nxt = S_JALR_ADR;
               is_lui:            nxt = S_LUI;
               default:           nxt = S_TRAP;
            endcase
         end
         S_MEMADR:   nxt = is_load ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD: begin
            if (MemReady_i)   nxt = S_MEMWB;
            else if (timeout) nxt = S_TRAP;
         end
         S_MEMWB:    nxt = S_FETCH;
         S_MEMWRITE: begin
            if (MemReady_i)   nxt = S_FETCH;
            else if (timeout) nxt = S_TRAP;
         end
         S_EXEC_R:   nxt = S_ALUWB;
         S_EXEC_I:   nxt = S_ALUWB;
         S_LUI:      nxt = S_ALUWB;
         S_ALUWB:    nxt = S_FETCH;
         S_BRANCH:   nxt = S_FETCH;
         S_JAL:      nxt = S_ALUWB;
         S_JALR_ADR: nxt = S_JAL;
         S_TRAP:     nxt = S_TRAP;
         default:    nxt = S_TRAP;
      endcase
   end

   // State register and stall counter; the counter restarts on any state change
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_FETCH;
         wcnt  <= '0;
      end else begin
         state <= nxt;
         if (WD_ON && stall && nxt == state)
            wcnt <= wcnt + 1'b1;
         else
            wcnt <= '0;
      end
   end

   // Datapath controls decoded from state; reset forces everything low at once
   always_comb begin
      ImmSrc_o    = 3'b000;
      PCWrite_o   = 1'b0;
      IRWrite_o   = 1'b0;
      AdrSrc_o    = 1'b0;
      MemRead_o   = 1'b0;
      MemWrite_o  = 1'b0;
      RegWrite_o  = 1'b0;
      ALUSrcA_o   = 2'b00;
      ALUSrcB_o   = 2'b00;
      ALUOp_o     = 2'b00;
      ResultSrc_o = 2'b00;
      Halted_o    = 1'b0;
      if (!rst) begin
         unique case (1'b1)
            is_store:  ImmSrc_o = 3'b001;
            is_branch: ImmSrc_o = 3'b010;
            is_lui:    ImmSrc_o = 3'b011;
            is_jal:    ImmSrc_o = 3'b100;
            default:   ImmSrc_o = 3'b000;
         endcase
         case (state)
            S_FETCH: begin
               MemRead_o = 1'b1;
               if (MemReady_i) begin
                  IRWrite_o   = 1'b1;
                  PCWrite_o   = 1'b1;
                  ALUSrcB_o   = 2'b10;
                  ResultSrc_o = 2'b10;
               end
            end
            S_DECODE: begin
               ALUSrcA_o = 2'b01;
               ALUSrcB_o = 2'b01;
            end
            S_MEMADR: begin
               ALUSrcA_o = 2'b10;
               ALUSrcB_o = 2'b01;
            end
            S_MEMREAD: begin
               AdrSrc_o  = 1'b1;
               MemRead_o = 1'b1;
            end
            S_MEMWB: begin
               ResultSrc_o = 2'b01;
               RegWrite_o  = 1'b1;
            end
            S_MEMWRITE: begin
               AdrSrc_o   = 1'b1;
               MemWrite_o = 1'b1;
            end
            S_EXEC_R: begin
               ALUSrcA_o = 2'b10;
               ALUOp_o   = 2'b10;
            end
            S_EXEC_I: begin
               ALUSrcA_o = 2'b10;
               ALUSrcB_o = 2'b01;
               ALUOp_o   = 2'b10;
            end
            S_LUI: begin
               ALUSrcB_o = 2'b01;
               ALUOp_o   = 2'b11;
            end
            S_ALUWB: begin
               RegWrite_o = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA_o = 2'b10;
               ALUOp_o   = 2'b01;
               PCWrite_o = BranchCond_i;
            end
            S_JAL: begin
               ALUSrcA_o = 2'b01;
               ALUSrcB_o = 2'b10;
               PCWrite_o = 1'b1;
            end
            S_JALR_ADR: begin
               ALUSrcA_o = 2'b10;
               ALUSrcB_o = 2'b01;
            end
            S_TRAP: begin
               Halted_o = 1'b1;
            end
            default: begin
               Halted_o = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: hand vector table, corner sequences,
// and random instruction streams against a phase-list reference model.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = '0;
   logic        rdy = 1'b0;
   logic        bc = 1'b0;
   logic [2:0]  ImmSrc_o;
   logic        PCWrite_o, IRWrite_o, AdrSrc_o;
   logic        MemRead_o, MemWrite_o, RegWrite_o;
   logic [1:0]  ALUSrcA_o, ALUSrcB_o, ALUOp_o, ResultSrc_o;
   logic        Halted_o;

   always #5 clk = ~clk;

   multicycle_ctrl #(.DATAWIDTH(32), .WAIT_LIMIT(16)) dut (
      .clk(clk), .rst(rst), .Instr_i(instr),
      .MemReady_i(rdy), .BranchCond_i(bc),
      .ImmSrc_o(ImmSrc_o), .PCWrite_o(PCWrite_o),
      .IRWrite_o(IRWrite_o), .AdrSrc_o(AdrSrc_o),
      .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
      .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
      .ALUSrcB_o(ALUSrcB_o), .ALUOp_o(ALUOp_o),
      .ResultSrc_o(ResultSrc_o), .Halted_o(Halted_o)
   );

   // en = {PCWrite, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite}
   typedef struct packed {
      logic [2:0] imm;
      logic [5:0] en;
      logic [1:0] a;
      logic [1:0] b;
      logic [1:0] op;
      logic [1:0] rs;
      logic       h;
   } out_t;

   typedef struct {
      logic [31:0] instr;
      logic        rdy;
      logic        bc;
      out_t        o;
   } vec_t;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_LW   = 32'h0000A183;
   localparam logic [31:0] I_SW   = 32'h0030A023;
   localparam logic [31:0] I_BEQ  = 32'h00208463;
   localparam logic [31:0] I_JAL  = 32'h008000EF;
   localparam logic [31:0] I_JALR = 32'h000080E7;
   localparam logic [31:0] I_LUI  = 32'h123450B7;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [31:0] I_BAD  = 32'h0000007F;

   int total = 0;
   int bad = 0;

   function automatic vec_t v(input logic [31:0] i, input logic r,
                              input logic c, input logic [2:0] imm,
                              input logic [5:0] en, input logic [1:0] a,
                              input logic [1:0] sb, input logic [1:0] op,
                              input logic [1:0] rs, input logic h);
      vec_t t;
      t.instr = i;
      t.rdy = r;
      t.bc = c;
      t.o = {imm, en, a, sb, op, rs, h};
      return t;
   endfunction

   function automatic out_t act();
      return {ImmSrc_o, PCWrite_o, IRWrite_o, AdrSrc_o, MemRead_o,
              MemWrite_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, ALUOp_o,
              ResultSrc_o, Halted_o};
   endfunction

   task automatic check(input string nm, input out_t e);
      out_t a;
      a = act();
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, a, e);
      end
   endtask

   // Called at a negedge; returns at the following negedge
   task automatic step(input string nm, input vec_t t);
      instr = t.instr;
      rdy = t.rdy;
      bc = t.bc;
      #1;
      check(nm, t.o);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset_zero", '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Reference model: expected outputs from the phase name
   function automatic logic [2:0] immf(input logic [6:0] op);
      case (op)
         7'h23:   return 3'b001;
         7'h63:   return 3'b010;
         7'h37:   return 3'b011;
         7'h6F:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic out_t expo(input string ph, input logic [31:0] i,
                                 input logic r, input logic cond);
      out_t e;
      e = '0;
      e.imm = immf(i[6:0]);
      case (ph)
         "F": begin
            if (r) begin
               e.en = 6'b110100;
               e.b = 2'b10;
               e.rs = 2'b10;
            end else e.en = 6'b000100;
         end
         "D":   begin e.a = 2'b01; e.b = 2'b01; end
         "MA":  begin e.a = 2'b10; e.b = 2'b01; end
         "MR":  e.en = 6'b001100;
         "MWB": begin e.en = 6'b000001; e.rs = 2'b01; end
         "MW":  e.en = 6'b001010;
         "XR":  begin e.a = 2'b10; e.op = 2'b10; end
         "XI":  begin e.a = 2'b10; e.b = 2'b01; e.op = 2'b10; end
         "LUI": begin e.b = 2'b01; e.op = 2'b11; end
         "WB":  e.en = 6'b000001;
         "BR":  begin e.en = {cond, 5'b0}; e.a = 2'b10; e.op = 2'b01; end
         "J":   begin e.en = 6'b100000; e.a = 2'b01; e.b = 2'b10; end
         "JA":  begin e.a = 2'b10; e.b = 2'b01; end
         "T":   e.h = 1'b1;
         default: e = '1;
      endcase
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  ops [10];
      logic [31:0] r;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
              7'h6F, 7'h67, 7'h37, 7'h7F, 7'h0F};
      r = $urandom();
      return {r[31:7], ops[$urandom_range(9)]};
   endfunction

   vec_t tbl[$];

   initial begin
      string ph;
      string q[$];
      int    wc;
      int    burst;
      int    tcnt;
      bit    newf;

      // add with two fetch stalls
      tbl.push_back(v(I_ADD,0,0,3'b000,6'b000100,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_ADD,0,0,3'b000,6'b000100,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_ADD,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_ADD,1,0,3'b000,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_ADD,1,0,3'b000,6'b000000,2'b10,2'b00,2'b10,2'b00,0));
      tbl.push_back(v(I_ADD,1,0,3'b000,6'b000001,2'b00,2'b00,2'b00,2'b00,0));
      // lw with three memory stalls
      tbl.push_back(v(I_LW,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_LW,1,0,3'b000,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_LW,1,0,3'b000,6'b000000,2'b10,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_LW,0,0,3'b000,6'b001100,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_LW,0,0,3'b000,6'b001100,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_LW,0,0,3'b000,6'b001100,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_LW,1,0,3'b000,6'b001100,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_LW,1,0,3'b000,6'b000001,2'b00,2'b00,2'b00,2'b01,0));
      // sw with one write stall
      tbl.push_back(v(I_SW,1,0,3'b001,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_SW,1,0,3'b001,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_SW,1,0,3'b001,6'b000000,2'b10,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_SW,0,0,3'b001,6'b001010,2'b00,2'b00,2'b00,2'b00,0));
      tbl.push_back(v(I_SW,1,0,3'b001,6'b001010,2'b00,2'b00,2'b00,2'b00,0));
      // beq taken then not taken
      tbl.push_back(v(I_BEQ,1,1,3'b010,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_BEQ,1,1,3'b010,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_BEQ,1,1,3'b010,6'b100000,2'b10,2'b00,2'b01,2'b00,0));
      tbl.push_back(v(I_BEQ,1,0,3'b010,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_BEQ,1,0,3'b010,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_BEQ,1,0,3'b010,6'b000000,2'b10,2'b00,2'b01,2'b00,0));
      // jal
      tbl.push_back(v(I_JAL,1,0,3'b100,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_JAL,1,0,3'b100,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_JAL,1,0,3'b100,6'b100000,2'b01,2'b10,2'b00,2'b00,0));
      tbl.push_back(v(I_JAL,1,0,3'b100,6'b000001,2'b00,2'b00,2'b00,2'b00,0));
      // jalr
      tbl.push_back(v(I_JALR,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_JALR,1,0,3'b000,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_JALR,1,0,3'b000,6'b000000,2'b10,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_JALR,1,0,3'b000,6'b100000,2'b01,2'b10,2'b00,2'b00,0));
      tbl.push_back(v(I_JALR,1,0,3'b000,6'b000001,2'b00,2'b00,2'b00,2'b00,0));
      // lui
      tbl.push_back(v(I_LUI,1,0,3'b011,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_LUI,1,0,3'b011,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_LUI,1,0,3'b011,6'b000000,2'b00,2'b01,2'b11,2'b00,0));
      tbl.push_back(v(I_LUI,1,0,3'b011,6'b000001,2'b00,2'b00,2'b00,2'b00,0));
      // addi
      tbl.push_back(v(I_ADDI,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_ADDI,1,0,3'b000,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_ADDI,1,0,3'b000,6'b000000,2'b10,2'b01,2'b10,2'b00,0));
      tbl.push_back(v(I_ADDI,1,0,3'b000,6'b000001,2'b00,2'b00,2'b00,2'b00,0));
      // unsupported opcode traps from decode and stays there
      tbl.push_back(v(I_BAD,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      tbl.push_back(v(I_BAD,1,0,3'b000,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      tbl.push_back(v(I_BAD,1,0,3'b000,6'b000000,2'b00,2'b00,2'b00,2'b00,1));
      tbl.push_back(v(I_BAD,1,1,3'b000,6'b000000,2'b00,2'b00,2'b00,2'b00,1));

      @(negedge clk);
      instr = I_SW;
      do_reset();
      foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

      // Reset asserted in the middle of a write drops MemWrite at once
      do_reset();
      step("mw_f", v(I_SW,1,0,3'b001,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      step("mw_d", v(I_SW,1,0,3'b001,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      step("mw_ma", v(I_SW,1,0,3'b001,6'b000000,2'b10,2'b01,2'b00,2'b00,0));
      step("mw_wait", v(I_SW,0,0,3'b001,6'b001010,2'b00,2'b00,2'b00,2'b00,0));
      rdy = 1'b0;
      #1;
      check("mw_held", {3'b001,6'b001010,2'b00,2'b00,2'b00,2'b00,1'b0});
      rst = 1'b1;
      #1;
      check("rst_mid_mw", '0);
      @(negedge clk);
      rst = 1'b0;
      step("post_rst", v(I_SW,0,0,3'b001,6'b000100,2'b00,2'b00,2'b00,2'b00,0));

      // Fetch watchdog: 16 stalled cycles then trap, trap is sticky
      do_reset();
      for (int k = 1; k <= 16; k++)
         step($sformatf("wd_f%0d", k),
              v(I_ADD,0,0,3'b000,6'b000100,2'b00,2'b00,2'b00,2'b00,0));
      step("wd_trap", v(I_ADD,0,0,3'b000,6'b000000,2'b00,2'b00,2'b00,2'b00,1));
      step("wd_stick", v(I_ADD,1,0,3'b000,6'b000000,2'b00,2'b00,2'b00,2'b00,1));

      // Ready in the limit cycle wins; counter restarts per state
      do_reset();
      for (int k = 1; k <= 15; k++)
         step("lim_f", v(I_LW,0,0,3'b000,6'b000100,2'b00,2'b00,2'b00,2'b00,0));
      step("lim_f16", v(I_LW,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));
      step("lim_d", v(I_LW,1,0,3'b000,6'b000000,2'b01,2'b01,2'b00,2'b00,0));
      step("lim_ma", v(I_LW,1,0,3'b000,6'b000000,2'b10,2'b01,2'b00,2'b00,0));
      for (int k = 1; k <= 15; k++)
         step("lim_mr", v(I_LW,0,0,3'b000,6'b001100,2'b00,2'b00,2'b00,2'b00,0));
      step("lim_mr16", v(I_LW,1,0,3'b000,6'b001100,2'b00,2'b00,2'b00,2'b00,0));
      step("lim_wb", v(I_LW,1,0,3'b000,6'b000001,2'b00,2'b00,2'b00,2'b01,0));
      step("lim_next", v(I_LW,1,0,3'b000,6'b110100,2'b00,2'b10,2'b00,2'b10,0));

      // Random streams against the phase-list model
      do_reset();
      ph = "F";
      q.delete();
      wc = 0;
      burst = 0;
      tcnt = 0;
      newf = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if (ph == "T" && tcnt >= 2) begin
            do_reset();
            ph = "F";
            q.delete();
            wc = 0;
            tcnt = 0;
            newf = 1'b1;
         end
         if (newf) instr = rand_instr();
         newf = 1'b0;
         if (burst > 0) begin
            rdy = 1'b0;
            burst--;
         end else if ($urandom_range(63) == 0) begin
            burst = $urandom_range(20, 10);
            rdy = 1'b0;
         end else rdy = ($urandom_range(3) != 0);
         bc = 1'($urandom_range(1));
         #1;
         check({"rand_", ph}, expo(ph, instr, rdy, bc));
         if (ph == "T") tcnt++;
         else if (ph == "F" || ph == "MR" || ph == "MW") begin
            if (rdy) begin
               wc = 0;
               if (ph == "F") ph = "D";
               else if (q.size() > 0) ph = q.pop_front();
               else ph = "F";
            end else begin
               wc++;
               if (wc == 16) begin
                  wc = 0;
                  ph = "T";
               end
            end
         end else if (ph == "D") begin
            case (instr[6:0])
               7'h03:   q = '{"MA", "MR", "MWB"};
               7'h23:   q = '{"MA", "MW"};
               7'h33:   q = '{"XR", "WB"};
               7'h13:   q = '{"XI", "WB"};
               7'h63:   q = '{"BR"};
               7'h6F:   q = '{"J", "WB"};
               7'h67:   q = '{"JA", "J", "WB"};
               7'h37:   q = '{"LUI", "WB"};
               default: q = '{"T"};
            endcase
            ph = q.pop_front();
         end else begin
            if (q.size() > 0) ph = q.pop_front();
            else ph = "F";
         end
         if (ph == "F") newf = 1'b1;
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
